// File: rtl/fp_unit_pkg.sv
// Shared definitions for the floating-point compare unit: op encodings,
// canonical NaN constants, pipeline depth bounds and operand classification.
package fp_unit_pkg;

   localparam int unsigned XLEN = 64;

   typedef enum logic [2:0] {
      OpEq  = 3'b000,
      OpLt  = 3'b001,
      OpLe  = 3'b010,
      OpMin = 3'b011,
      OpMax = 3'b100
   } fp_op_e;

   localparam logic [XLEN-1:0] CANON_NAN_S = 64'hFFFF_FFFF_7FC0_0000;
   localparam logic [XLEN-1:0] CANON_NAN_D = 64'h7FF8_0000_0000_0000;

   localparam int unsigned PIPE_STAGES_MIN = 1;
   localparam int unsigned PIPE_STAGES_MAX = 4;

   typedef struct packed {
      logic        sign;
      logic [62:0] mag;   // exponent and mantissa, zero-extended for single
      logic        nan;
      logic        snan;
   } fp_class_t;

   // Out-of-range depths are pulled back into the legal window.
   function automatic int unsigned clamp_stages(input int unsigned n);
      if (n < PIPE_STAGES_MIN) return PIPE_STAGES_MIN;
      if (n > PIPE_STAGES_MAX) return PIPE_STAGES_MAX;
      return n;
   endfunction

   // Single format looks only at bits [31:0]; the upper half is ignored.
   function automatic fp_class_t classify(input logic [XLEN-1:0] x, input logic dbl);
      fp_class_t c;
      if (dbl) begin
         c.sign = x[63];
         c.mag  = x[62:0];
         c.nan  = (&x[62:52]) & (|x[51:0]);
         c.snan = c.nan & ~x[51];
      end else begin
         c.sign = x[31];
         c.mag  = {32'd0, x[30:0]};
         c.nan  = (&x[30:23]) & (|x[22:0]);
         c.snan = c.nan & ~x[22];
      end
      return c;
   endfunction

endpackage

// File: rtl/fp_cmp_core.sv
// Combinational IEEE-754 compare / min / max for single and double operands.
module fp_cmp_core
   import fp_unit_pkg::*;
(
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  logic [2:0]      op_i,
   input  logic            fmt_i,
   output logic [XLEN-1:0] res_o,
   output logic            nv_o
);

   fp_class_t       ca;
   fp_class_t       cb;
   logic            both_zero;
   logic            ord_lt;
   logic            lt_val;
   logic            eq_val;
   logic            any_nan;
   logic            any_snan;
   logic [XLEN-1:0] a_box;
   logic [XLEN-1:0] b_box;
   logic [XLEN-1:0] canon;

   // Classify operands and derive ordering relations.
   always_comb begin
      ca        = classify(a_i, fmt_i);
      cb        = classify(b_i, fmt_i);
      both_zero = (ca.mag == 63'd0) && (cb.mag == 63'd0);
      // Total order with -0 < +0; negatives order by reversed magnitude.
      if (ca.sign != cb.sign) begin
         ord_lt = ca.sign;
      end else if (ca.sign) begin
         ord_lt = ca.mag > cb.mag;
      end else begin
         ord_lt = ca.mag < cb.mag;
      end
      lt_val   = ord_lt & ~both_zero;
      eq_val   = both_zero | ((ca.sign == cb.sign) && (ca.mag == cb.mag));
      any_nan  = ca.nan | cb.nan;
      any_snan = ca.snan | cb.snan;
      a_box    = fmt_i ? a_i : {32'hFFFF_FFFF, a_i[31:0]};
      b_box    = fmt_i ? b_i : {32'hFFFF_FFFF, b_i[31:0]};
      canon    = fmt_i ? CANON_NAN_D : CANON_NAN_S;
   end

   // Select the result and invalid flag for the requested operation.
   always_comb begin
      res_o = '0;
      nv_o  = 1'b0;
      case (op_i)
         OpEq: begin
            res_o = {63'd0, eq_val & ~any_nan};
            nv_o  = any_snan;
         end
         OpLt: begin
            res_o = {63'd0, lt_val & ~any_nan};
            nv_o  = any_nan;
         end
         OpLe: begin
            res_o = {63'd0, (lt_val | eq_val) & ~any_nan};
            nv_o  = any_nan;
         end
         OpMin, OpMax: begin
            if (ca.nan && cb.nan) begin
               res_o = canon;
            end else if (ca.nan) begin
               res_o = b_box;
            end else if (cb.nan) begin
               res_o = a_box;
            end else if (op_i == OpMin) begin
               res_o = ord_lt ? a_box : b_box;
            end else begin
               res_o = ord_lt ? b_box : a_box;
            end
            nv_o = any_snan;
         end
         default: begin
            res_o = '0;
            nv_o  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/fp_cmp_pipe.sv
// Stall-all pipeline around fp_cmp_core with valid/ready handshake,
// synchronous flush and a sticky invalid-operation flag.
module fp_cmp_pipe
   import fp_unit_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 64,
   parameter int unsigned PIPE_STAGES = 2
) (
   input  logic                  in_clk,
   input  logic                  in_rst,
   input  logic                  in_valid,
   output logic                  out_ready,
   input  logic [DATA_WIDTH-1:0] in_numA,
   input  logic [DATA_WIDTH-1:0] in_numB,
   input  logic [2:0]            in_op,
   input  logic                  in_fmt,
   input  logic                  in_flush,
   input  logic                  in_flag_clr,
   output logic                  out_valid,
   input  logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_flag_NV,
   output logic                  out_flag_NV_sticky
);

   localparam int unsigned Stages = clamp_stages(PIPE_STAGES);

   logic [DATA_WIDTH-1:0] core_res;
   logic                  core_nv;
   logic                  advance;

   logic [Stages-1:0]     vld_q;
   logic [Stages-1:0]     vld_d;
   logic [Stages-1:0]     nv_q;
   logic [Stages-1:0]     nv_d;
   logic [DATA_WIDTH-1:0] data_q [Stages];
   logic [DATA_WIDTH-1:0] data_d [Stages];
   logic                  sticky_q;
   logic                  sticky_d;

   fp_cmp_core u_core (
      .a_i   (in_numA),
      .b_i   (in_numB),
      .op_i  (in_op),
      .fmt_i (in_fmt),
      .res_o (core_res),
      .nv_o  (core_nv)
   );

   // Whole pipeline moves when the output slot is free or being drained.
   always_comb begin
      advance   = ~vld_q[Stages-1] | in_ready;
      out_ready = advance;
   end

   // Stage shifting; flush drops every valid including the incoming operand.
   always_comb begin
      vld_d = vld_q;
      nv_d  = nv_q;
      for (int i = 0; i < Stages; i++) begin
         data_d[i] = data_q[i];
      end
      if (advance) begin
         vld_d[0]  = in_valid;
         nv_d[0]   = core_nv;
         data_d[0] = core_res;
         for (int i = 1; i < Stages; i++) begin
            vld_d[i]  = vld_q[i-1];
            nv_d[i]   = nv_q[i-1];
            data_d[i] = data_q[i-1];
         end
      end
      if (in_flush) begin
         vld_d = '0;
      end
   end

   // Sticky NV: a set on an output transfer wins over a simultaneous clear.
   always_comb begin
      sticky_d = (out_valid & in_ready & out_flag_NV) | (sticky_q & ~in_flag_clr);
   end

   // Pipeline and flag registers.
   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         vld_q    <= '0;
         nv_q     <= '0;
         sticky_q <= 1'b0;
         for (int i = 0; i < Stages; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         vld_q    <= vld_d;
         nv_q     <= nv_d;
         sticky_q <= sticky_d;
         for (int i = 0; i < Stages; i++) begin
            data_q[i] <= data_d[i];
         end
      end
   end

   // Outputs come straight from the last stage.
   always_comb begin
      out_valid          = vld_q[Stages-1];
      out_data           = data_q[Stages-1];
      out_flag_NV        = nv_q[Stages-1];
      out_flag_NV_sticky = sticky_q;
   end

endmodule
